// File: rtl/spi_px_master_pkg.sv
// Shared sobel-chip parameters: pixel width and the SPI master state encoding.
package spi_px_master_pkg;

   localparam int PIXEL_WIDTH = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

endpackage

// File: rtl/spi_px_master_clk_div.sv
// SCK half-period tick generator; counter is held cleared while disabled so it
// restarts cleanly each time the enable rises.
module spi_clk_div #(
   parameter int HALF_PERIOD = 2
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic en,
   output logic tick
);

   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(HALF_PERIOD - 1));

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i)
         cnt <= '0;
      else if (!en || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/spi_px_master.sv
// SPI mode-0 full-duplex master: one PIXEL_WIDTH-bit pixel out and one word in
// per chip-select frame, MSB first, all outputs registered.
module spi_px_master #(
   parameter int HALF_PERIOD = 2,
   parameter int PIXEL_WIDTH = spi_px_master_pkg::PIXEL_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic [PIXEL_WIDTH-1:0] tx_px_i,
   input  logic                   tx_valid_i,
   output logic                   tx_ready_o,
   output logic [PIXEL_WIDTH-1:0] rx_px_o,
   output logic                   rx_valid_o,
   output logic                   spi_sck_o,
   output logic                   spi_cs_o,
   output logic                   spi_sdo_o,
   input  logic                   spi_sdi_i
);

   import spi_px_master_pkg::*;

   localparam int BW = $clog2(PIXEL_WIDTH);

   spi_state_t             state, next_state;
   logic                   tick, accept, last_bit, div_en;
   logic                   cs_nx, ready_nx;
   logic [PIXEL_WIDTH-1:0] tx_sr, rx_sr;
   logic [BW-1:0]          bit_cnt;

   assign accept   = (state == ST_IDLE) && tx_valid_i && tx_ready_o;
   assign last_bit = (bit_cnt == BW'(PIXEL_WIDTH - 1));
   assign div_en   = (state != ST_IDLE);

   spi_clk_div #(.HALF_PERIOD(HALF_PERIOD)) u_clk_div (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .en       (div_en),
      .tick     (tick)
   );

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // After the last falling edge SHIFT waits one more low half-period before HOLD.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (accept) next_state = ST_SETUP;
         ST_SETUP: if (tick) next_state = ST_SHIFT;
         ST_SHIFT: if (tick && !spi_sck_o && last_bit) next_state = ST_HOLD;
         ST_HOLD:  if (tick) next_state = ST_GAP;
         ST_GAP:   if (tick) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      cs_nx    = !(next_state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      ready_nx = (next_state == ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         spi_cs_o   <= 1'b1;
         tx_ready_o <= 1'b0;
      end else begin
         spi_cs_o   <= cs_nx;
         tx_ready_o <= ready_nx;
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         spi_sck_o  <= 1'b0;
         spi_sdo_o  <= 1'b0;
         rx_px_o    <= '0;
         rx_valid_o <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               tx_sr     <= tx_px_i;
               spi_sdo_o <= tx_px_i[PIXEL_WIDTH-1];
               rx_sr     <= '0;
               bit_cnt   <= '0;
            end
            ST_SETUP: if (tick) begin
               spi_sck_o <= 1'b1;
               rx_sr     <= {rx_sr[PIXEL_WIDTH-2:0], spi_sdi_i};
            end
            ST_SHIFT: if (tick) begin
               if (spi_sck_o) begin
                  // Zero fill makes sdo drop to 0 after the final bit.
                  spi_sck_o <= 1'b0;
                  tx_sr     <= {tx_sr[PIXEL_WIDTH-2:0], 1'b0};
                  spi_sdo_o <= tx_sr[PIXEL_WIDTH-2];
               end else if (!last_bit) begin
                  spi_sck_o <= 1'b1;
                  rx_sr     <= {rx_sr[PIXEL_WIDTH-2:0], spi_sdi_i};
                  bit_cnt   <= bit_cnt + 1'b1;
               end
            end
            ST_HOLD: if (tick) begin
               rx_px_o    <= rx_sr;
               rx_valid_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/spi_px_master.md
SPI_PX_MASTER -- requirements
Module: spi_px_master

Interface
REQ-001 Parameter HALF_PERIOD, default 2, meaning clk_i cycles per SCK half-period; legal range >= 1.
REQ-002 Parameter PIXEL_WIDTH, default taken from the shared parameters file, meaning bits per SPI transaction in each direction.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 nreset_i  input  1  reset, asynchronous, active-low.
REQ-005 tx_px_i  input  PIXEL_WIDTH  pixel to send to the sobel chip.
REQ-006 tx_valid_i  input  1  tx_px_i is valid.
REQ-007 tx_ready_o  output  1  block can accept a pixel.
REQ-008 rx_px_o  output  PIXEL_WIDTH  word captured from the chip during the last transaction.
REQ-009 rx_valid_o  output  1  one-cycle pulse; rx_px_o has just been updated.
REQ-010 spi_sck_o  output  1  SPI clock, CPOL=0.
REQ-011 spi_cs_o  output  1  chip select, active-low.
REQ-012 spi_sdo_o  output  1  MOSI, to the chip's spi_sdi.
REQ-013 spi_sdi_i  input  1  MISO, from the chip's spi_sdo.

Function
REQ-014 Protocol SHALL be SPI mode 0, full duplex, MSB first, exactly PIXEL_WIDTH bits per transaction in each direction.
REQ-015 States: IDLE, SETUP, SHIFT, HOLD, GAP; only IDLE asserts tx_ready_o.
REQ-016 IDLE: cs=1, sck=0; accept on tx_valid_i & tx_ready_o, load the TX shift register, go to SETUP; on the next cycle cs=0 and sdo=tx_px_i[MSB].
REQ-017 SETUP: hold cs=0, sck=0 for HALF_PERIOD cycles, then raise sck and go to SHIFT.
REQ-018 SHIFT: toggle sck every HALF_PERIOD cycles; in the cycle sck rises, capture spi_sdi_i into the RX shift-register LSB (shift left); in the cycle sck falls, shift the TX register and drive the next bit on sdo.
REQ-019 Bit counter SHALL count rising edges 0..PIXEL_WIDTH-1; after the PIXEL_WIDTH-th falling edge go to HOLD with sck=0.
REQ-020 HOLD: cs=0, sck=0 for HALF_PERIOD cycles, then cs=1, rx_px_o <= RX register, rx_valid_o=1 for one cycle, go to GAP.
REQ-021 GAP: cs=1 for HALF_PERIOD cycles, then go to IDLE; minimum cs-high time between transactions is HALF_PERIOD cycles.
REQ-022 rx_valid_o SHALL assert exactly (2*PIXEL_WIDTH+2)*HALF_PERIOD cycles after the accepting clock edge.
REQ-023 tx_valid_i outside IDLE SHALL be ignored, with no effect on the transaction in flight.
REQ-024 sdo SHALL be held stable from one falling sck edge (or cs fall) to the next; after the last bit, sdo SHALL be 0.
REQ-025 rx_px_o SHALL hold its value between rx_valid_o pulses.
REQ-026 Any non-IDLE state SHALL return to IDLE with sck=0 and cs=1 within 1 cycle of nreset_i falling.

Reset
REQ-027 Asynchronous on nreset_i low: state=IDLE, spi_cs_o=1, spi_sck_o=0, spi_sdo_o=0, tx_ready_o=0 while in reset, rx_px_o=0, rx_valid_o=0, all counters and shift registers 0.
REQ-028 After release, tx_ready_o SHALL be 1 on the first clock edge; a partially shifted transaction SHALL never produce rx_valid_o.

Structure
REQ-029 PIXEL_WIDTH and the state enum type SHALL live in the shared parameters file/package used by the sobel blocks.
REQ-030 The SCK half-period tick counter SHALL be one sub-module, spi_clk_div (enable, tick output, restarts on enable rise).
REQ-031 All outputs SHALL be driven directly from flops, with no combinational path from spi_sdi_i.

Verification
REQ-032 Loopback (spi_sdi_i=spi_sdo_o), PIXEL_WIDTH=24, HALF_PERIOD=2, tx=0xA5C33C -> rx_px_o=0xA5C33C and rx_valid_o exactly 100 cycles after accept.
REQ-033 Slave model driving 0x123456 on falling edges, tx=0xFFFFFF -> rx_px_o=0x123456; monitor sees MOSI bits 24x '1', MSB first, with exactly 24 sck rising edges while cs=0.
REQ-034 tx_valid_i held high with values 0x000001 then 0x800000 -> two transactions with cs high for >= 2 cycles between them; second MOSI frame begins with '1'.
REQ-035 Pulse tx_valid_i during SHIFT with a different pixel -> ignored; the frame in flight is unchanged, and tx_ready_o=0 until GAP completes.
REQ-036 Assert nreset_i after bit 10 -> cs=1, sck=0 asynchronously, no rx_valid_o; the next transaction after release completes normally.
REQ-037 HALF_PERIOD=1, loopback 0x5A5A5A -> correct data, rx_valid_o at cycle 50.
